// File: rtl/apb_initiator_if.sv
// Bundles the request/response handshake and the APB3 bus of the
// apb_initiator. The master modport is the initiator's view; the slave
// modport is the view of whatever sits on the other side (requester plus
// responders, e.g. a testbench).
interface apb_initiator_if #(
  parameter int NR_SLAVES = 4,
  parameter int ADDR_W    = 5
);
  // Request channel
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  // Response channel
  logic                      resp_valid;
  logic                      resp_ready;
  logic [31:0]               resp_rdata;
  logic                      resp_err;
  // APB3 bus
  logic [NR_SLAVES-1:0]      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [31:0]               PWDATA;
  logic [32*NR_SLAVES-1:0]   PRDATA;
  logic [NR_SLAVES-1:0]      PREADY;
  logic [NR_SLAVES-1:0]      PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_initiator.sv
// APB3 requester: converts a valid/ready request into an APB SETUP/ACCESS
// transfer to one of up to four responders, returns read data plus an error
// flag, and bounds every ACCESS phase with an optional timeout.
// The interface instance must be parameterised with the same NR_SLAVES and
// ADDR_W as this module.
module apb_initiator #(
  parameter int NR_SLAVES = 4,
  parameter int ADDR_W    = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  apb_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // A zero TIMEOUT disables the watchdog; otherwise the transfer is killed
  // on the ACCESS edge where the counter has reached TIMEOUT-1.
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t                 state_reg, state_next;
  logic [NR_SLAVES-1:0]   psel_reg, psel_next;
  logic                   penable_reg, penable_next;
  logic                   pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0]      paddr_reg, paddr_next;
  logic [31:0]            pwdata_reg, pwdata_next;
  logic                   resp_valid_reg, resp_valid_next;
  logic [31:0]            resp_rdata_reg, resp_rdata_next;
  logic                   resp_err_reg, resp_err_next;
  logic [15:0]            tmo_cnt_reg, tmo_cnt_next;

  // Responder index decode from the request address
  logic [1:0] req_idx;
  logic       idx_ok;
  assign req_idx = bus.req_addr[ADDR_W+1:ADDR_W];
  assign idx_ok  = ({1'b0, req_idx} < 3'(NR_SLAVES));

  // Address bits above the responder index carry no meaning here
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  // Selected-responder mux: the one-hot PSEL masks every responder so that
  // unselected PREADY/PSLVERR/PRDATA can never leak into the response.
  logic [NR_SLAVES-1:0] ready_masked;
  logic [NR_SLAVES-1:0] err_masked;
  logic [31:0]          rdata_terms [NR_SLAVES];
  logic                 sel_ready;
  logic                 sel_err;
  logic [31:0]          sel_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < NR_SLAVES; gi++) begin : g_sel
      assign ready_masked[gi] = bus.PREADY[gi] & psel_reg[gi];
      assign err_masked[gi]   = bus.PSLVERR[gi] & psel_reg[gi];
      assign rdata_terms[gi]  = bus.PRDATA[32*gi +: 32] & {32{psel_reg[gi]}};
    end
  endgenerate

  assign sel_ready = |ready_masked;
  assign sel_err   = |err_masked;

  // OR-combine the masked read data slices
  always_comb begin
    sel_rdata = 32'd0;
    for (int i = 0; i < NR_SLAVES; i++) begin
      sel_rdata = sel_rdata | rdata_terms[i];
    end
  end

  logic tmo_expire;
  assign tmo_expire = TMO_EN && (tmo_cnt_reg == TMO_LAST);

  // State and registered-output register; reset abandons any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      psel_reg       <= '0;
      penable_reg    <= 1'b0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
      tmo_cnt_reg    <= 16'd0;
    end else begin
      state_reg      <= state_next;
      psel_reg       <= psel_next;
      penable_reg    <= penable_next;
      pwrite_reg     <= pwrite_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      tmo_cnt_reg    <= tmo_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid) state_next = idx_ok ? SETUP : RESP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (sel_ready || tmo_expire) state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    psel_next       = psel_reg;
    penable_next    = penable_reg;
    pwrite_next     = pwrite_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    resp_valid_next = resp_valid_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          pwrite_next = bus.req_write;
          paddr_next  = bus.req_addr[ADDR_W-1:0];
          pwdata_next = bus.req_wdata;
          if (idx_ok) begin
            for (int i = 0; i < NR_SLAVES; i++) begin
              psel_next[i] = (req_idx == 2'(i));
            end
            penable_next = 1'b0;
          end else begin
            // Nonexistent responder: answer immediately with an error
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'hffff_ffff;
          end
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        tmo_cnt_next = 16'd0;
      end
      ACCESS: begin
        if (sel_ready) begin
          // A PREADY on the expiry edge still completes normally
          psel_next       = '0;
          penable_next    = 1'b0;
          resp_valid_next = 1'b1;
          resp_err_next   = sel_err;
          resp_rdata_next = pwrite_reg ? 32'd0 : sel_rdata;
        end else if (tmo_expire) begin
          psel_next       = '0;
          penable_next    = 1'b0;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
          resp_rdata_next = 32'hffff_ffff;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 16'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) resp_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.PSEL       = psel_reg;
  assign bus.PENABLE    = penable_reg;
  assign bus.PWRITE     = pwrite_reg;
  assign bus.PADDR      = paddr_reg;
  assign bus.PWDATA     = pwdata_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator with three responders and an
// eight-cycle timeout. A transaction-level model predicts select, ACCESS
// length, error and read data for each transfer.
module tb_apb_initiator;
  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  apb_initiator_if #(.NR_SLAVES(NS), .ADDR_W(AW)) bus ();

  apb_initiator #(.NR_SLAVES(NS), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level expectation for one transfer. wait_n is the number of
  // ACCESS cycles the responder holds PREADY low before raising it.
  function automatic void ref_model(input bit wr, input logic [31:0] addr,
                                    input int wait_n, input bit serr,
                                    input logic [31:0] rd, output bit bad,
                                    output logic [NS-1:0] psel, output int acc,
                                    output bit err, output logic [31:0] rdata);
    int idx;
    idx  = int'(addr[AW+1:AW]);
    bad  = (idx >= NS);
    psel = bad ? '0 : NS'(1 << idx);
    if (bad) begin
      acc = 0; err = 1'b1; rdata = 32'hffff_ffff;
    end else if (wait_n >= TMO) begin
      acc = TMO; err = 1'b1; rdata = 32'hffff_ffff;
    end else begin
      acc = wait_n + 1; err = serr; rdata = wr ? 32'd0 : rd;
    end
  endfunction

  // One complete transfer, from an idle negedge to the negedge after the
  // response is consumed.
  task automatic run_xfer(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_n, input bit serr,
                          input logic [31:0] rd, input int bp);
    bit bad, eerr, done;
    logic [NS-1:0] epsel;
    logic [31:0] erdata;
    int eacc, acc, idx;
    logic [AW-1:0] eaddr;
    ref_model(wr, addr, wait_n, serr, rd, bad, epsel, eacc, eerr, erdata);
    idx   = int'(addr[AW+1:AW]);
    eaddr = addr[AW-1:0];
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready_idle: got %b want 1", name, bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    if (bad) begin
      checks++; if (bus.PSEL !== '0) begin errors++; $display("FAIL %s bad_psel: got %b want 0", name, bus.PSEL); end
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL %s bad_resp_valid: got %b want 1", name, bus.resp_valid); end
    end else begin
      checks++; if (bus.PSEL !== epsel) begin errors++; $display("FAIL %s setup_psel: got %b want %b", name, bus.PSEL, epsel); end
      checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL %s setup_penable: got %b want 0", name, bus.PENABLE); end
      checks++; if (bus.PADDR !== eaddr) begin errors++; $display("FAIL %s setup_paddr: got %h want %h", name, bus.PADDR, eaddr); end
      checks++; if (bus.PWRITE !== wr) begin errors++; $display("FAIL %s setup_pwrite: got %b want %b", name, bus.PWRITE, wr); end
      checks++; if (bus.PWDATA !== wd) begin errors++; $display("FAIL %s setup_pwdata: got %h want %h", name, bus.PWDATA, wd); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL %s setup_req_ready: got %b want 0", name, bus.req_ready); end
      @(posedge clk); @(negedge clk);
      checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL %s access_penable: got %b want 1", name, bus.PENABLE); end
      acc = 0; done = 1'b0;
      while (!done && acc < 64) begin
        acc++;
        for (int i = 0; i < NS; i++) begin
          if (i == idx) begin
            bus.PREADY[i] = (acc > wait_n); bus.PSLVERR[i] = serr; bus.PRDATA[32*i +: 32] = rd;
          end else begin
            bus.PREADY[i] = 1'($urandom); bus.PSLVERR[i] = 1'($urandom); bus.PRDATA[32*i +: 32] = $urandom;
          end
        end
        checks++;
        if (bus.PSEL !== epsel || bus.PENABLE !== 1'b1 || bus.PADDR !== eaddr ||
            bus.PWDATA !== wd || bus.PWRITE !== wr || bus.resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s access_stable: cyc %0d psel %b en %b addr %h wdata %h wr %b rv %b want psel %b en 1 addr %h wdata %h wr %b rv 0",
                   name, acc, bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PWRITE, bus.resp_valid, epsel, eaddr, wd, wr);
        end
        @(posedge clk); @(negedge clk);
        if (bus.resp_valid === 1'b1) done = 1'b1;
      end
      bus.PREADY = '0;
      checks++; if (!done) begin errors++; $display("FAIL %s resp_wait_bound: got no resp_valid want resp within %0d cycles", name, eacc); end
      checks++; if (acc !== eacc) begin errors++; $display("FAIL %s access_cycles: got %0d want %0d", name, acc, eacc); end
      checks++; if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL %s resp_bus_idle: got psel %b en %b want 0 0", name, bus.PSEL, bus.PENABLE); end
    end
    checks++; if (bus.resp_err !== eerr) begin errors++; $display("FAIL %s resp_err: got %b want %b", name, bus.resp_err, eerr); end
    checks++; if (bus.resp_rdata !== erdata) begin errors++; $display("FAIL %s resp_rdata: got %h want %h", name, bus.resp_rdata, erdata); end
    bus.resp_ready = (bp == 0);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== erdata || bus.resp_err !== eerr ||
          bus.req_ready !== 1'b0 || bus.PSEL !== '0) begin
        errors++;
        $display("FAIL %s backpressure_hold: cyc %0d rv %b rdata %h err %b rr %b psel %b want 1 %h %b 0 0",
                 name, k, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, bus.PSEL, erdata, eerr);
      end
      if (k == bp - 1) bus.resp_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL %s resp_consumed: got %b want 0", name, bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready_after: got %b want 1", name, bus.req_ready); end
    checks++; if (bus.PADDR !== eaddr || bus.PWRITE !== wr || bus.PWDATA !== wd) begin errors++; $display("FAIL %s bus_hold_after: got %h %b %h want %h %b %h", name, bus.PADDR, bus.PWRITE, bus.PWDATA, eaddr, wr, wd); end
    $display("xfer %-10s wr=%0d addr=%h wdata=%h wait=%0d bp=%0d -> err=%0d rdata=%h",
             name, wr, addr, wd, wait_n, bp, eerr, erdata);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0) begin errors++; $display("FAIL reset_apb_ctl: got %b %b %b want 0 0 0", bus.PSEL, bus.PENABLE, bus.PWRITE); end
    checks++; if (bus.PADDR !== '0 || bus.PWDATA !== 32'd0) begin errors++; $display("FAIL reset_apb_data: got %h %h want 0 0", bus.PADDR, bus.PWDATA); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b %h %b want 0 0 0", bus.resp_valid, bus.resp_rdata, bus.resp_err); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    reset = 1'b0;
  endtask

  task automatic test_read();
    run_xfer("read_r2", 1'b0, 32'h0000_004C, 32'h0, 0, 1'b0, 32'h1234_5678, 0);
  endtask

  task automatic test_write_wait();
    run_xfer("write_wait", 1'b1, 32'h0000_0028, 32'hA5A5_A5A5, 5, 1'b0, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_slverr();
    run_xfer("slverr", 1'b0, 32'h0000_0004, 32'h0, 0, 1'b1, 32'h0BAD_0BAD, 0);
    run_xfer("after_err", 1'b0, 32'h0000_0010, 32'h0, 1, 1'b0, 32'h600D_600D, 0);
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 1'b0, 32'h0000_0024, 32'h0, TMO, 1'b0, 32'h1111_2222, 0);
    run_xfer("ready_last", 1'b0, 32'h0000_0024, 32'h0, TMO - 1, 1'b0, 32'h3333_4444, 0);
  endtask

  task automatic test_bad_index();
    run_xfer("bad_index", 1'b0, 32'h0000_0064, 32'h0, 0, 1'b0, 32'h0, 0);
    run_xfer("bad_idx_wr", 1'b1, 32'hFFFF_FFFF, 32'h5555_AAAA, 0, 1'b0, 32'h0, 2);
  endtask

  task automatic test_backpressure();
    run_xfer("backpress", 1'b0, 32'h0000_0044, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 10);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    run_xfer("b2b_0", 1'b1, 32'h0000_0001, 32'h0101_0101, 0, 1'b0, 32'h0, 0);
    run_xfer("b2b_1", 1'b0, 32'h0000_0022, 32'h0, 0, 1'b0, 32'h2222_2222, 0);
    run_xfer("b2b_2", 1'b1, 32'h0000_0043, 32'h0303_0303, 0, 1'b0, 32'h0, 0);
    checks++; if (cyc - c0 !== 12) begin errors++; $display("FAIL back_to_back_cycles: got %0d want 12", cyc - c0); end
  endtask

  task automatic test_reset_mid_access();
    bus.PREADY = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0031; bus.req_wdata = 32'h7777_8888;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access: got %b want 1", bus.PENABLE); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b %b %b want 0 0 0", bus.PSEL, bus.PENABLE, bus.resp_valid); end
    checks++; if (bus.PADDR !== '0 || bus.PWDATA !== 32'd0) begin errors++; $display("FAIL rst_mid_data: got %h %h want 0 0", bus.PADDR, bus.PWDATA); end
    bus.PREADY = '1; bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_stale: cyc %0d got rv %b rr %b want 0 1", k, bus.resp_valid, bus.req_ready); end
    end
    bus.PREADY = '0; bus.resp_ready = 1'b0;
    $display("xfer %-10s reset during ACCESS, no response expected", "rst_mid");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      bus.resp_ready = 1'($urandom);
      run_xfer($sformatf("rand_%0d", n), 1'($urandom), addr, $urandom,
               $urandom_range(0, 10), 1'($urandom), $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.resp_ready = 1'b0;
    bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_bad_index();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
APB3 requester (master) that turns a simple valid/ready request/response interface into APB transfers to up to four APB responders, such as the interrupt controller, UART and timers.
- Decodes a responder index from the request address and drives a one-hot PSEL.
- Sequences the SETUP/ACCESS phases and waits on PREADY; responders without PREADY tie it high.
- Returns read data and an error flag.
- Guards every access with a timeout so a hung responder cannot stall the requester.

Parameters:
- NR_SLAVES, 4: number of responders, 1..4; index = req_addr[ADDR_W+1:ADDR_W].
- ADDR_W, 5: width of PADDR, i.e. the per-responder offset.
- TIMEOUT, 255: maximum ACCESS cycles before forced termination; 0 disables the timeout; max 65535.

Ports:
- clk  in  1  clock (also PCLK)
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; [ADDR_W+1:ADDR_W] selects the responder, upper bits ignored
- req_wdata  in  32  write data
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when high together with resp_valid
- resp_rdata  out  32  read data
- resp_err  out  1  PSLVERR, timeout or bad index
- PSEL  out  NR_SLAVES  one-hot responder select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  transfer direction
- PADDR  out  ADDR_W  req_addr[ADDR_W-1:0]
- PWDATA  out  32  write data
- PRDATA  in  32*NR_SLAVES  responder i read data at [32*i+31:32*i]
- PREADY  in  NR_SLAVES  per-responder ready
- PSLVERR  in  NR_SLAVES  per-responder error

Behaviour:
- Outputs: every APB output and every resp_* output is registered. req_ready is combinational and equals (state == IDLE).
- Reset: state IDLE; PSEL 0, PENABLE 0, PWRITE 0, PADDR 0, PWDATA 0; resp_valid 0, resp_rdata 0, resp_err 0; timeout counter 0.
- Reset mid-transfer: the transfer is abandoned and the outputs above take effect on that edge; no response is issued.
- IDLE, on accept (req_valid & req_ready) at edge t:
  - Latch write, address and wdata.
  - If index < NR_SLAVES: go to SETUP. PSEL[index] = 1, PENABLE = 0, PWRITE/PADDR/PWDATA valid from t+1.
  - If index >= NR_SLAVES: go to RESP with resp_err = 1, resp_rdata = 32'hffffffff. No APB activity.
- SETUP, always exactly one cycle: go to ACCESS, PENABLE = 1 from t+2. Clear the timeout counter.
- ACCESS: PSEL, PENABLE, PWRITE, PADDR and PWDATA are held stable.
  - PREADY[sel] == 1 sampled at an edge:
    - resp_rdata = PRDATA slice for reads, 0 for writes.
    - resp_err = PSLVERR[sel].
    - PSEL = 0, PENABLE = 0; go to RESP.
  - PREADY[sel] == 0: the counter increments.
  - TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY still low:
    - Terminate: PSEL/PENABLE = 0, resp_err = 1, resp_rdata = 32'hffffffff; go to RESP.
    - A PREADY arriving on that same edge wins; the transfer completes normally.
  - PREADY/PSLVERR/PRDATA of unselected responders are ignored.
- RESP: resp_valid = 1; resp_rdata and resp_err are held until the edge where resp_ready = 1. On that edge resp_valid = 0 and the state returns to IDLE.
  - resp_ready may already be high; it is only honoured while in RESP.
- After a transfer PADDR, PWDATA and PWRITE keep their last values; they are only updated on accept.
- Latency with PREADY tied high and resp_ready high:
  - accept at t; PSEL at t+1; PENABLE at t+2; resp_valid at t+3; req_ready high again at t+4.
  - Back-to-back transfers: 4 cycles each.
- Only one outstanding transfer; req_ready is low in SETUP, ACCESS and RESP.

Test Plan:
- Read, responder 2 (ADDR_W=5): req_addr=0x4C, PREADY=1, PRDATA[2]=0x12345678 -> PSEL=0100 and PADDR=0x0C at t+1; PENABLE at t+2; resp_valid at t+3 with rdata=0x12345678, err=0.
- Write with wait states: write 0xA5A5A5A5 to responder 1 offset 0x08, PREADY[1] low for 5 ACCESS cycles -> PWDATA/PADDR/PSEL stable throughout; resp at the cycle after PREADY; err=0, rdata=0.
- PSLVERR: responder 0 returns PREADY=1, PSLVERR=1 -> resp_err=1; next request accepted normally.
- Timeout: TIMEOUT=8, PREADY never asserted -> PSEL drops after 8 ACCESS cycles; resp_err=1, rdata=0xffffffff. PREADY on cycle 8 -> normal completion instead.
- Bad index: NR_SLAVES=3, index 3 -> no PSEL bit ever set; resp_valid at t+1 with err=1.
- Backpressure/reset: resp_ready held low for 10 cycles -> resp stable, req_ready low. Reset asserted in ACCESS -> PSEL/PENABLE/resp_valid 0 after that edge; no stale response afterwards.
